// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the chess-board state store.
//   - piece type codes (low three bits of every piece code)
//   - COLOUR_BIT: colour position inside the canonical 4-bit start code
//   - hist_entry_t: one undo record, sized for the largest supported board
//   - board_state_e: controller states
//   - start_piece(): canonical 4-bit start-position code of a square
package board_pkg;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] KING   = 3'd2;
    localparam logic [2:0] QUEEN  = 3'd3;
    localparam logic [2:0] KNIGHT = 3'd4;
    localparam logic [2:0] BISHOP = 3'd5;
    localparam logic [2:0] ROOK   = 3'd6;

    // Colour sits at bit 3 of the canonical code returned by start_piece;
    // the store relocates it to bit PW-1 of its own piece width.
    localparam int COLOUR_BIT = 3;

    // History fields are sized for boards up to 256x256 and pieces up to 8 bits;
    // the store fills the low bits and leaves the rest zero.
    localparam int HC_W = 8;
    localparam int HP_W = 8;

    typedef struct packed {
        logic [HC_W-1:0] fx;
        logic [HC_W-1:0] fy;
        logic [HC_W-1:0] tx;
        logic [HC_W-1:0] ty;
        logic [HP_W-1:0] moved;
        logic [HP_W-1:0] captured;
    } hist_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } board_state_e;

    // Only the standard 8-file layout is populated; other widths start empty.
    function automatic logic [3:0] start_piece(input int x, input int y,
                                               input int files, input int ranks);
        logic [2:0] back;
        logic [3:0] code;
        case (x)
            0, 7:    back = ROOK;
            1, 6:    back = KNIGHT;
            2, 5:    back = BISHOP;
            3:       back = QUEEN;
            4:       back = KING;
            default: back = EMPTY;
        endcase
        code = 4'b0000;
        if (files == 8) begin
            if (y == 0)              code = {1'b1, back};
            else if (y == 1)         code = {1'b1, PAWN};
            else if (y == ranks - 1) code = {1'b0, back};
            else if (y == ranks - 2) code = {1'b0, PAWN};
        end
        return code;
    endfunction

endpackage

// File: rtl/board_hist.sv
// board_hist: circular LIFO of undo records.
//   Clk, reset   : clock, synchronous active-high reset (empties the buffer)
//   clear        : drop all entries
//   push         : store push_ent as newest; overwrites the oldest when full
//   pop          : discard the newest entry (ignored when empty)
//   push_ent     : record to store
//   top_ent      : newest record (meaningful only when count != 0)
//   count        : number of valid records, saturating at HDEPTH
// clear has priority over push, push over pop.
module board_hist
    import board_pkg::*;
#(
    parameter int HDEPTH = 16,
    parameter int HW     = $clog2(HDEPTH + 1)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  hist_entry_t   push_ent,
    output hist_entry_t   top_ent,
    output logic [HW-1:0] count
);

    localparam int PTRW = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;

    hist_entry_t     mem_q [HDEPTH];
    hist_entry_t     mem_d [HDEPTH];
    logic [PTRW-1:0] head_q, head_d;   // next slot to write
    logic [HW-1:0]   count_q, count_d;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(HDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTRW-1:0] ptr_dec(input logic [PTRW-1:0] p);
        return (p == '0) ? PTRW'(HDEPTH - 1) : p - 1'b1;
    endfunction

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push) begin
            mem_d[head_q] = push_ent;
            head_d        = ptr_inc(head_q);
            if (count_q != HW'(HDEPTH)) count_d = count_q + 1'b1;
        end else if (pop && (count_q != '0)) begin
            head_d  = ptr_dec(head_q);
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign top_ent = mem_q[ptr_dec(head_q)];
    assign count   = count_q;

endmodule

// File: rtl/board_store.sv
// board_store: chess-board state store with atomic moves and undo.
//   Clk, reset            : clock, synchronous active-high reset (restarts init)
//   wr_en/wr_x/wr_y/wr_data : raw square write; also empties the undo history
//   mv_valid/mv_ready     : move request handshake
//   mv_fx/mv_fy/mv_tx/mv_ty : move source and destination squares
//   mv_promo_en/mv_promo  : piece placed on the destination instead of the mover
//   un_valid/un_ready     : undo request handshake
//   mv_err/un_err         : one-cycle pulses after a rejected move/undo
//   rd_x/rd_y/rd_data     : NRD packed combinational read ports
//   busy                  : start position is still being written
//   hist_count            : number of undoable moves
// Handshake: a request is taken on a rising Clk edge where valid and ready are
// both high; ready never depends on the request's own payload, and a requester
// whose ready is low keeps valid asserted until it is taken.
module board_store
    import board_pkg::*;
#(
    parameter  int FILES  = 8,
    parameter  int RANKS  = 8,
    parameter  int PW     = 4,
    parameter  int NRD    = 4,
    parameter  int HDEPTH = 16,
    localparam int XW     = $clog2(FILES),
    localparam int YW     = $clog2(RANKS),
    localparam int HW     = $clog2(HDEPTH + 1)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [XW-1:0]     wr_x,
    input  logic [YW-1:0]     wr_y,
    input  logic [PW-1:0]     wr_data,
    input  logic              mv_valid,
    output logic              mv_ready,
    input  logic [XW-1:0]     mv_fx,
    input  logic [YW-1:0]     mv_fy,
    input  logic [XW-1:0]     mv_tx,
    input  logic [YW-1:0]     mv_ty,
    input  logic              mv_promo_en,
    input  logic [PW-1:0]     mv_promo,
    input  logic              un_valid,
    output logic              un_ready,
    output logic              mv_err,
    output logic              un_err,
    input  logic [NRD*XW-1:0] rd_x,
    input  logic [NRD*YW-1:0] rd_y,
    output logic [NRD*PW-1:0] rd_data,
    output logic              busy,
    output logic [HW-1:0]     hist_count
);

    localparam int NBITS = FILES * RANKS * PW;
    localparam int BW    = $clog2(NBITS);

    board_state_e     state_q, state_d;
    logic [YW-1:0]    row_q, row_d;
    logic [NBITS-1:0] board_q, board_d;
    logic             mv_err_q, mv_err_d;
    logic             un_err_q, un_err_d;

    logic             hist_push, hist_pop, hist_clear;
    hist_entry_t      push_ent, top_ent;
    logic [PW-1:0]    src_piece, cap_piece;
    logic             mv_bad;
    logic             unused_hist;

    function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (int'(x) < FILES) && (int'(y) < RANKS);
    endfunction

    function automatic logic [BW-1:0] sq_base(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return BW'((int'(y) * FILES + int'(x)) * PW);
    endfunction

    // Move the canonical colour bit up to the top of a PW-bit code.
    function automatic logic [PW-1:0] expand(input logic [3:0] c);
        logic [PW-1:0] p;
        p         = '0;
        p[PW-1]   = c[COLOUR_BIT];
        p[2:0]    = c[2:0];
        return p;
    endfunction

    always_comb begin
        src_piece = '0;
        cap_piece = '0;
        if (in_range(mv_fx, mv_fy)) src_piece = board_q[sq_base(mv_fx, mv_fy) +: PW];
        if (in_range(mv_tx, mv_ty)) cap_piece = board_q[sq_base(mv_tx, mv_ty) +: PW];
        mv_bad = !in_range(mv_fx, mv_fy) || !in_range(mv_tx, mv_ty)
              || ((mv_fx == mv_tx) && (mv_fy == mv_ty))
              || (src_piece[2:0] == EMPTY);
        // The moved piece is recorded before any promotion so undo restores it.
        push_ent                   = '0;
        push_ent.fx[XW-1:0]        = mv_fx;
        push_ent.fy[YW-1:0]        = mv_fy;
        push_ent.tx[XW-1:0]        = mv_tx;
        push_ent.ty[YW-1:0]        = mv_ty;
        push_ent.moved[PW-1:0]     = src_piece;
        push_ent.captured[PW-1:0]  = cap_piece;
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        board_d    = board_q;
        mv_err_d   = 1'b0;
        un_err_d   = 1'b0;
        hist_push  = 1'b0;
        hist_pop   = 1'b0;
        hist_clear = 1'b0;
        case (state_q)
            ST_INIT: begin
                for (int x = 0; x < FILES; x++) begin
                    board_d[BW'((int'(row_q) * FILES + x) * PW) +: PW] =
                        expand(start_piece(x, int'(row_q), FILES, RANKS));
                end
                if (int'(row_q) == RANKS - 1) state_d = ST_IDLE;
                else                          row_d   = row_q + 1'b1;
            end
            ST_IDLE: begin
                if (wr_en) begin
                    if (in_range(wr_x, wr_y)) board_d[sq_base(wr_x, wr_y) +: PW] = wr_data;
                    hist_clear = 1'b1;
                end else if (mv_valid) begin
                    if (mv_bad) begin
                        mv_err_d = 1'b1;
                    end else begin
                        board_d[sq_base(mv_tx, mv_ty) +: PW] = mv_promo_en ? mv_promo : src_piece;
                        board_d[sq_base(mv_fx, mv_fy) +: PW] = '0;
                        hist_push = 1'b1;
                    end
                end else if (un_valid) begin
                    if (hist_count == '0) begin
                        un_err_d = 1'b1;
                    end else begin
                        board_d[sq_base(top_ent.fx[XW-1:0], top_ent.fy[YW-1:0]) +: PW] =
                            top_ent.moved[PW-1:0];
                        board_d[sq_base(top_ent.tx[XW-1:0], top_ent.ty[YW-1:0]) +: PW] =
                            top_ent.captured[PW-1:0];
                        hist_pop = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            row_q    <= '0;
            mv_err_q <= 1'b0;
            un_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            mv_err_q <= mv_err_d;
            un_err_q <= un_err_d;
        end
    end

    // Contents are rebuilt by the init sweep, so the array needs no reset.
    always_ff @(posedge Clk) begin
        board_q <= board_d;
    end

    board_hist #(
        .HDEPTH (HDEPTH),
        .HW     (HW)
    ) u_hist (
        .Clk      (Clk),
        .reset    (reset),
        .clear    (hist_clear),
        .push     (hist_push),
        .pop      (hist_pop),
        .push_ent (push_ent),
        .top_ent  (top_ent),
        .count    (hist_count)
    );

    // Only the low bits of each history field carry information.
    assign unused_hist = ^top_ent;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (in_range(rd_x[i*XW +: XW], rd_y[i*YW +: YW]))
                rd_data[i*PW +: PW] = board_q[sq_base(rd_x[i*XW +: XW], rd_y[i*YW +: YW]) +: PW];
        end
    end

    assign busy     = (state_q == ST_INIT);
    assign mv_ready = (state_q == ST_IDLE) && !wr_en;
    assign un_ready = (state_q == ST_IDLE) && !wr_en && !mv_valid;
    assign mv_err   = mv_err_q;
    assign un_err   = un_err_q;

endmodule
